// File: rtl/ps2_host_tx_if.sv
// Command/status handshake between the IO controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
   logic [7:0] Tx_Byte;
   logic       Tx_Start;
   logic       Tx_Busy;
   logic       Tx_Done;
   logic       Tx_Error;

   modport master (output Tx_Byte, Tx_Start, input Tx_Busy, Tx_Done, Tx_Error);
   modport slave  (input Tx_Byte, Tx_Start, output Tx_Busy, Tx_Done, Tx_Error);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame clocked by
// the device, ACK check, with an overall timeout. Lines are driven via pull-low enables.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic         Fast_Clock,
   input  logic         Reset_N,
   ps2_host_tx_if.slave tx,
   input  logic         KB_Clk_In,
   input  logic         KB_Data_In,
   output logic         KB_Clk_OE,
   output logic         KB_Data_OE
);
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FW = $clog2(FILTER_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAIT_IDLE, S_FAIL
   } state_t;

   // Synchronizers and filter rest at the idle (released, high) bus level.
   logic [1:0]    clk_sync, data_sync;
   logic          clk_filt, clk_filt_d;
   logic [FW-1:0] flt_cnt;
   logic          clk_s, data_s, fall;

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];
   assign fall   = clk_filt_d & ~clk_filt;

   always_ff @(posedge Fast_Clock or negedge Reset_N)
      if (!Reset_N) begin
         clk_sync   <= 2'b11;
         data_sync  <= 2'b11;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
         flt_cnt    <= '0;
      end else begin
         clk_sync   <= {clk_sync[0], KB_Clk_In};
         data_sync  <= {data_sync[0], KB_Data_In};
         clk_filt_d <= clk_filt;
         // Filtered clock follows only after FILTER_LEN consecutive differing samples.
         if (clk_s == clk_filt)
            flt_cnt <= '0;
         else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s;
            flt_cnt  <= '0;
         end else
            flt_cnt <= flt_cnt + 1'b1;
      end

   state_t        state, state_n;
   logic [9:0]    shreg, shreg_n;
   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [IW-1:0] inh_cnt, inh_cnt_n;
   logic [TW-1:0] to_cnt, to_cnt_n;
   logic          clk_oe_n, data_oe_n;
   logic          busy, busy_n, done, done_n, error, error_n;
   logic          to_hit;

   assign tx.Tx_Busy  = busy;
   assign tx.Tx_Done  = done;
   assign tx.Tx_Error = error;

   // The counter would reach TIMEOUT_CYCLES-1 on this edge.
   assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 2));

   always_ff @(posedge Fast_Clock or negedge Reset_N)
      if (!Reset_N) begin
         state      <= S_IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         inh_cnt    <= '0;
         to_cnt     <= '0;
         KB_Clk_OE  <= 1'b0;
         KB_Data_OE <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_n;
         shreg      <= shreg_n;
         bit_cnt    <= bit_cnt_n;
         inh_cnt    <= inh_cnt_n;
         to_cnt     <= to_cnt_n;
         KB_Clk_OE  <= clk_oe_n;
         KB_Data_OE <= data_oe_n;
         busy       <= busy_n;
         done       <= done_n;
         error      <= error_n;
      end

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      inh_cnt_n = inh_cnt;
      to_cnt_n  = to_cnt;
      clk_oe_n  = KB_Clk_OE;
      data_oe_n = KB_Data_OE;
      busy_n    = busy;
      done_n    = 1'b0;
      error_n   = 1'b0;
      unique case (state)
         S_IDLE: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            busy_n    = 1'b0;
            bit_cnt_n = '0;
            inh_cnt_n = '0;
            to_cnt_n  = '0;
            if (tx.Tx_Start) begin
               shreg_n  = {1'b1, ~^tx.Tx_Byte, tx.Tx_Byte};
               busy_n   = 1'b1;
               clk_oe_n = 1'b1;
               state_n  = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            inh_cnt_n = inh_cnt + 1'b1;
            // Start bit is already on the line during the last clock-low cycle.
            if (inh_cnt == IW'(INHIBIT_CYCLES - 2))
               data_oe_n = 1'b1;
            if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
               clk_oe_n = 1'b0;
               state_n  = S_REQ;
            end
         end
         S_REQ, S_DATA, S_ACK, S_WAIT_IDLE: begin
            to_cnt_n = to_cnt + 1'b1;
            if (to_hit) begin
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b0;
               state_n   = S_FAIL;
            end else if (state == S_REQ || state == S_DATA) begin
               if (fall) begin
                  data_oe_n = ~shreg[0];
                  shreg_n   = {1'b0, shreg[9:1]};
                  bit_cnt_n = (state == S_REQ) ? 4'd1 : bit_cnt + 4'd1;
                  if (state == S_REQ)
                     state_n = S_DATA;
                  else if (bit_cnt == 4'd9)
                     state_n = S_ACK;
               end
            end else if (state == S_ACK) begin
               if (fall)
                  state_n = data_s ? S_FAIL : S_WAIT_IDLE;
            end else if (clk_s && data_s) begin
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end
         end
         S_FAIL: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            error_n   = 1'b1;
            busy_n    = 1'b0;
            state_n   = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end
endmodule
